// File: rtl/cpu.sv
// rtl/cpu.sv - fixed-point 16.8 restoring divider with internal data memory
module cpu_dm (
  input  logic        Clk,
  input  logic        we,
  input  logic [23:0] wdata,
  output logic [15:0] dividend,
  output logic [7:0]  divisor
);
  reg [7:0] Core [0:255];

  // Quotient bytes are written together, big-endian, when the result is stored
  always @(posedge Clk) begin
    if (we) begin
      Core[4] <= wdata[23:16];
      Core[5] <= wdata[15:8];
      Core[6] <= wdata[7:0];
    end
  end

  assign dividend = {Core[0], Core[1]};
  assign divisor  = Core[2];
endmodule

module cpu (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] n_q, n_d;
  logic [8:0]  r_q, r_d;
  logic [23:0] q_q, q_d;
  logic [7:0]  dvs_q, dvs_d;
  logic        ack_q, ack_d;

  logic [15:0] mem_dividend;
  logic [7:0]  mem_divisor;
  logic        mem_we;
  logic [8:0]  r_shift;
  logic        fits;

  cpu_dm DM1 (
    .Clk      (Clk),
    .we       (mem_we),
    .wdata    (q_q),
    .dividend (mem_dividend),
    .divisor  (mem_divisor)
  );

  // A reset landing on the store edge must abort the write-back too
  assign mem_we = (state_q == STORE) && !Reset;
  assign Ack    = ack_q;

  // Next-state logic: launch, one restoring-division step per cycle, store, done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    ack_d   = ack_q;
    r_shift = 9'((r_q << 1) | 9'(n_q[23]));
    fits    = (r_shift >= {1'b0, dvs_q});
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          n_d     = {mem_dividend, 8'h00};
          dvs_d   = mem_divisor;
          r_d     = 9'd0;
          q_d     = 24'd0;
          cnt_d   = 5'd0;
          ack_d   = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        // A zero divisor always "fits", which yields the all-ones quotient
        n_d   = {n_q[22:0], 1'b0};
        r_d   = fits ? (r_shift - {1'b0, dvs_q}) : r_shift;
        q_d   = {q_q[22:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = STORE;
        end
      end
      STORE: begin
        ack_d   = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      n_q     <= 24'd0;
      r_q     <= 9'd0;
      q_q     <= 24'd0;
      dvs_q   <= 8'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - randomized self-checking bench for cpu against a behavioural model
module tb_cpu;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic Ack;

  cpu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  logic [15:0] op_dvd = 16'd0;
  logic [7:0]  op_dvs = 8'd0;

  int          m_busy = 0;
  logic        m_ack  = 1'b0;
  logic [23:0] m_q    = 24'd0;
  logic [23:0] m_mem  = 24'd0;

  function automatic logic [23:0] ref_q(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) return 24'hFFFFFF;
    return 24'((32'(a) * 32'd256) / 32'(b));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] dm_q();
    return {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6]};
  endfunction

  task automatic set_ops(input logic [15:0] a, input logic [7:0] b);
    op_dvd = a;
    op_dvs = b;
    dut.DM1.Core[0] = a[15:8];
    dut.DM1.Core[1] = a[7:0];
    dut.DM1.Core[2] = b;
  endtask

  task automatic preset(input logic [23:0] v);
    dut.DM1.Core[4] = v[23:16];
    dut.DM1.Core[5] = v[15:8];
    dut.DM1.Core[6] = v[7:0];
    m_mem = v;
  endtask

  // Model: a run is busy for 25 edges after launch; result lands on the last one
  always @(posedge Clk) begin
    if (Reset) begin
      m_busy = 0;
      m_ack  = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ack = 1'b1;
        m_mem = m_q;
      end
    end else if (Start) begin
      m_busy = 25;
      m_ack  = 1'b0;
      m_q    = ref_q(op_dvd, op_dvs);
    end
  end

  // Per-cycle compare of Ack and the result bytes against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("ack_cycle", 32'(Ack), 32'(m_ack));
      chk("mem_cycle", 32'(dm_q()), 32'(m_mem));
    end
  end

  task automatic launch_wait(output int lat);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("ack_drop_on_start", 32'(Ack), 32'd0);
    lat = 0;
    while (!Ack && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic run_case(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [23:0] expq);
    int lat;
    @(negedge Clk);
    set_ops(a, b);
    launch_wait(lat);
    chk({name, "_latency"}, 32'(lat), 32'd25);
    chk({name, "_q"}, 32'(dm_q()), 32'(expq));
  endtask

  initial begin
    int lat;
    int n;
    logic [15:0] ra;
    logic [7:0]  rb;

    repeat (3) @(negedge Clk);
    chk("reset_ack", 32'(Ack), 32'd0);
    Reset = 1'b0;
    preset(24'hA5A5A5);
    chk_en = 1'b1;
    repeat (3) @(negedge Clk);
    chk("idle_ack", 32'(Ack), 32'd0);

    chk("model_385_6", 32'(ref_q(16'd385, 8'd6)), 32'h00402A);
    chk("model_1_3", 32'(ref_q(16'd1, 8'd3)), 32'h000055);

    run_case("d385_6", 16'd385, 8'd6, 24'h00402A);
    run_case("d65535_1", 16'd65535, 8'd1, 24'hFFFF00);
    run_case("d65535_255", 16'd65535, 8'd255, 24'h010100);
    run_case("d1_255", 16'd1, 8'd255, 24'h000001);
    run_case("d1_3", 16'd1, 8'd3, 24'h000055);
    run_case("div0", 16'd1234, 8'd0, 24'hFFFFFF);

    // Reset mid-run aborts the write-back
    @(negedge Clk);
    set_ops(16'd385, 8'd6);
    preset(24'hA5A5A5);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (30) @(negedge Clk);
    chk("abort_ack", 32'(Ack), 32'd0);
    chk("abort_mem", 32'(dm_q()), 32'hA5A5A5);
    run_case("after_abort", 16'd385, 8'd6, 24'h00402A);

    // Second Start during DIV is ignored
    @(negedge Clk);
    set_ops(16'd1, 8'd3);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(negedge Clk);
      lat++;
    end
    Start = 1'b1;
    @(negedge Clk);
    lat++;
    Start = 1'b0;
    while (!Ack && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    chk("restart_ignored_latency", 32'(lat), 32'd25);
    chk("restart_ignored_q", 32'(dm_q()), 32'h000055);

    // Start held high relaunches on every DONE
    @(negedge Clk);
    set_ops(16'd1000, 8'd7);
    Start = 1'b1;
    repeat (80) @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (!(Ack && m_busy == 0) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("held_start_done", 32'(n < 40), 32'd1);
    chk("held_start_q", 32'(dm_q()), 32'h008EDB);

    // Randomized operands, including occasional zero divisor
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_case("rand", ra, rb, ref_q(ra, rb));
    end

    repeat (3) @(negedge Clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
